stream_mux_n: RTL and testbench
===============================

Name: stream_mux_n

Overview:
- Parametrised N-channel, WIDTH-bit stream multiplexer with valid/ready handshakes on every input and on the output.
- Selects one input per cycle, either by an explicit select (fixed mode) or by round-robin over the valid channels.
- Captures the chosen word into a one-entry output register.
- Feeds shared datapath consumers (ALU operand and writeback paths) where several producers compete and the consumer can stall.

Parameters:
- WIDTH, 32, data width per channel.
- N, 6, number of input channels, legal range 2..16.
- SELW, $clog2(N), select/source index width. Derived; must not be overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_data  input  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  N  per-channel valid.
- in_ready  output  N  per-channel ready; at most one bit high per cycle.
- sel  input  SELW  channel index used in fixed mode.
- mode  input  1  0 = fixed (MODE_FIXED), 1 = round-robin (MODE_RR).
- out_data  output  WIDTH  registered selected word.
- out_valid  output  1  out_data holds an unconsumed word.
- out_ready  input  1  consumer accepts out_data.
- out_src  output  SELW  index of the channel that supplied out_data.
- sel_err  output  1  registered one-cycle pulse: fixed mode, sel >= N, and the register could accept.

Behaviour:
- Reset values: out_valid=0, out_data=0, out_src=0, sel_err=0, rr_ptr=N-1.
  - Reset has priority over every other event in the same cycle.
  - A word held in the register is discarded, not delivered.
- accept = !out_valid || out_ready. This is combinational; there is no skid buffer.
- Grant is computed combinationally each cycle.
  - Fixed mode: candidate = sel when sel < N. grant = candidate if in_valid[candidate] && accept, else no grant.
  - RR mode: scan channels rr_ptr+1, rr_ptr+2, ... modulo N, wrapping from N-1 to 0. The first channel with in_valid=1 is granted if accept=1.
- in_ready[i] = accept && (grant == i). In RR mode in_ready depends combinationally on in_valid.
- Transfer on channel i happens when in_valid[i] && in_ready[i]. On the next edge:
  - out_data <= word i;
  - out_src <= i;
  - out_valid <= 1.
- Output drain without a transfer in the same cycle: out_valid && out_ready with no grant -> out_valid <= 0. out_data and out_src hold their old values.
- Stall: out_valid && !out_ready -> out_data and out_src stay stable, and all in_ready are 0.
- Simultaneous drain and transfer: the register reloads. Sustained throughput is 1 word/cycle.
- Latency: 1 cycle from input transfer to out_valid.
- rr_ptr updates to the granted index only on a transfer, in either mode.
  - Fixed-mode transfers therefore also move the RR start point.
  - Mode changes take effect in the same cycle, with no state flush.
- Fixed mode with sel >= N:
  - no grant; all in_ready = 0;
  - sel_err <= accept on the next edge;
  - otherwise sel_err <= 0.
  - This replaces the former "output zero" behaviour for an illegal select.
- No input valid: no grant, the register drains normally, rr_ptr holds.
- Inputs have no obligation to hold valid. Only the handshake defines a transfer.

Decomposition:
- Package stream_mux_pkg holds:
  - MODE_FIXED = 1'b0, MODE_RR = 1'b1;
  - the rule that SELW is $clog2(N), with a wrap-increment function next_idx(idx, N).
- Sub-module rr_arbiter_n (parameter N) contains the pure combinational round-robin grant.
  - Inputs: req[N], ptr[SELW], en.
  - Outputs: gnt_valid, gnt_idx.
  - The parent owns rr_ptr and the output register.

Test Plan:
1. Reset, then fixed mode with sel=2, in_valid=6'b000100, in_data ch2=32'hA5A5_0002, out_ready=1 -> in_ready=6'b000100. Next cycle out_valid=1, out_data=32'hA5A5_0002, out_src=2.
2. RR mode, all six valid, out_ready=1 for 8 cycles -> out_src sequence 0,1,2,3,4,5,0,1, one word per cycle, exactly one in_ready bit high each cycle.
3. Backpressure: word from ch1 held while out_ready=0 for 3 cycles -> out_data and out_src stable, in_ready=0. On the cycle out_ready returns to 1, the next word from ch2 (RR, all valid) loads.
4. Fixed mode with sel=7 (N=6), ch0 valid, out empty -> in_ready=0, sel_err pulses 1 cycle, out_valid stays 0. Change sel to 0 -> ch0 transfers.
5. RR after rr_ptr=3, only ch1 and ch5 valid -> ch5 granted first, then ch1 (wrap), then ch5.
6. reset asserted while out_valid=1 and out_ready=0 -> next cycle out_valid=0, out_data=0, out_src=0, sel_err=0. The first RR grant after reset goes to ch0.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared constants and index helpers for the N-channel stream multiplexer.
package stream_mux_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   // Width of a channel index for an N-channel mux.
   function automatic int sel_w(input int n);
      return $clog2(n);
   endfunction

   // Wrap-increment of a channel index; out-of-range inputs restart at 0.
   function automatic int next_idx(input int idx, input int n);
      return (idx >= n - 1) ? 0 : idx + 1;
   endfunction

endpackage

// File: rtl/stream_mux_n_rr_arbiter.sv
// Combinational round-robin grant: first requester after ptr, wrapping at N-1.
module rr_arbiter_n
   import stream_mux_pkg::*;
#(
   parameter  int N    = 6,
   localparam int SELW = sel_w(N)
) (
   input  logic [N-1:0]    req,
   input  logic [SELW-1:0] ptr,
   input  logic            en,
   output logic            gnt_valid,
   output logic [SELW-1:0] gnt_idx
);

   int               cand;
   logic [SELW-1:0]  cand_idx;

   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      cand      = int'(ptr);
      cand_idx  = '0;
      for (int k = 0; k < N; k++) begin
         cand     = next_idx(cand, N);
         cand_idx = SELW'(cand);
         if (en && !gnt_valid && req[cand_idx]) begin
            gnt_valid = 1'b1;
            gnt_idx   = cand_idx;
         end
      end
   end

endmodule

// File: rtl/stream_mux_n.sv
// N-channel valid/ready stream mux (fixed select or round-robin) feeding a
// one-entry output register that reloads on the same cycle it drains.
module stream_mux_n
   import stream_mux_pkg::*;
#(
   parameter  int WIDTH = 32,
   parameter  int N     = 6,
   localparam int SELW  = sel_w(N)
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N*WIDTH-1:0]   in_data,
   input  logic [N-1:0]         in_valid,
   output logic [N-1:0]         in_ready,
   input  logic [SELW-1:0]      sel,
   input  logic                 mode,
   output logic [WIDTH-1:0]     out_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [SELW-1:0]      out_src,
   output logic                 sel_err
);

   if (N < 2 || N > 16) begin : g_bad_n
      $error("stream_mux_n: N must be in 2..16");
   end

   logic              out_valid_q, out_valid_d;
   logic [WIDTH-1:0]  out_data_q,  out_data_d;
   logic [SELW-1:0]   out_src_q,   out_src_d;
   logic              sel_err_q,   sel_err_d;
   logic [SELW-1:0]   rr_ptr_q,    rr_ptr_d;

   logic              accept;
   logic              sel_ok;
   logic              fx_valid;
   logic              rr_valid;
   logic [SELW-1:0]   rr_idx;
   logic              grant_valid;
   logic [SELW-1:0]   grant_idx;

   assign accept = !out_valid_q || out_ready;
   assign sel_ok = (int'(sel) < N);

   rr_arbiter_n #(.N(N)) u_arb (
      .req       (in_valid),
      .ptr       (rr_ptr_q),
      .en        (accept && (mode == MODE_RR)),
      .gnt_valid (rr_valid),
      .gnt_idx   (rr_idx)
   );

   // A grant already implies accept and a valid requester, so it is the transfer.
   always_comb begin
      fx_valid    = (mode == MODE_FIXED) && sel_ok && accept && in_valid[sel];
      grant_valid = (mode == MODE_RR) ? rr_valid : fx_valid;
      grant_idx   = (mode == MODE_RR) ? rr_idx : sel;
      in_ready    = '0;
      if (grant_valid) in_ready[grant_idx] = 1'b1;
   end

   always_comb begin
      out_valid_d = grant_valid ? 1'b1 : (out_valid_q && !out_ready);
      out_data_d  = out_data_q;
      out_src_d   = out_src_q;
      rr_ptr_d    = rr_ptr_q;
      sel_err_d   = (mode == MODE_FIXED) && !sel_ok && accept;
      if (grant_valid) begin
         out_data_d = in_data[int'(grant_idx)*WIDTH +: WIDTH];
         out_src_d  = grant_idx;
         rr_ptr_d   = grant_idx;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_src_q   <= '0;
         sel_err_q   <= 1'b0;
         rr_ptr_q    <= SELW'(N - 1);
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_src_q   <= out_src_d;
         sel_err_q   <= sel_err_d;
         rr_ptr_q    <= rr_ptr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_src   = out_src_q;
   assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_stream_mux_n.sv
// Bench for stream_mux_n: directed vector table, then random traffic vs a reference model.
module tb_stream_mux_n;

   localparam int W  = 32;
   localparam int N  = 6;
   localparam int SW = 3;
   localparam logic [W-1:0] K = 32'hA5A5_0000;

   logic            clk = 1'b0;
   logic            reset;
   logic [N*W-1:0]  in_data;
   logic [N-1:0]    in_valid;
   logic [N-1:0]    in_ready;
   logic [SW-1:0]   sel;
   logic            mode;
   logic [W-1:0]    out_data;
   logic            out_valid;
   logic            out_ready;
   logic [SW-1:0]   out_src;
   logic            sel_err;

   always #5 clk = ~clk;

   stream_mux_n #(.WIDTH(W), .N(N)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .sel       (sel),
      .mode      (mode),
      .out_data  (out_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_src   (out_src),
      .sel_err   (sel_err)
   );

   typedef struct packed {
      logic          rst;
      logic          md;
      logic [SW-1:0] sl;
      logic [N-1:0]  iv;
      logic          ordy;
      logic [N-1:0]  erdy;
      logic          eov;
      logic [W-1:0]  eod;
      logic [SW-1:0] esrc;
      logic          eerr;
   } vec_t;

   vec_t tbl[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   // Reference model state, expressed in plain integers.
   bit           m_ov  = 1'b0;
   logic [W-1:0] m_od  = '0;
   int           m_src = 0;
   bit           m_err = 1'b0;
   int           m_ptr = N - 1;

   task automatic add(input logic rst, input logic md, input logic [SW-1:0] sl,
                      input logic [N-1:0] iv, input logic ordy, input logic [N-1:0] erdy,
                      input logic eov, input logic [W-1:0] eod, input logic [SW-1:0] esrc,
                      input logic eerr);
      vec_t v;
      v.rst = rst; v.md = md; v.sl = sl; v.iv = iv; v.ordy = ordy;
      v.erdy = erdy; v.eov = eov; v.eod = eod; v.esrc = esrc; v.eerr = eerr;
      tbl.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   function automatic int model_grant(input logic md, input logic [SW-1:0] s,
                                      input logic [N-1:0] v, input logic ordy);
      bit acc;
      acc = !m_ov || ordy;
      if (!acc) return -1;
      if (md == 1'b0) begin
         if (int'(s) < N && v[s]) return int'(s);
         return -1;
      end
      for (int k = 1; k <= N; k++) begin
         if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
      end
      return -1;
   endfunction

   function automatic logic [N-1:0] model_rdy(input int g);
      logic [N-1:0] e;
      e = '0;
      if (g >= 0) e[g] = 1'b1;
      return e;
   endfunction

   task automatic model_step(input logic r, input logic md, input logic [SW-1:0] s,
                             input logic [N-1:0] v, input logic ordy, input logic [N*W-1:0] d);
      int g;
      bit acc;
      g   = model_grant(md, s, v, ordy);
      acc = !m_ov || ordy;
      if (r) begin
         m_ov = 1'b0; m_od = '0; m_src = 0; m_err = 1'b0; m_ptr = N - 1;
      end else begin
         m_err = (md == 1'b0) && (int'(s) >= N) && acc;
         if (g >= 0) begin
            m_ov = 1'b1; m_od = d[g*W +: W]; m_src = g; m_ptr = g;
         end else if (ordy) begin
            m_ov = 1'b0;
         end
      end
   endtask

   // Drive on the falling edge, sample in_ready before the rising edge, outputs just after.
   task automatic apply(input logic r, input logic md, input logic [SW-1:0] s,
                        input logic [N-1:0] v, input logic ordy, input logic [N*W-1:0] d,
                        output logic [N-1:0] rdy, output logic ov, output logic [W-1:0] od,
                        output logic [SW-1:0] src, output logic err);
      @(negedge clk);
      reset = r; mode = md; sel = s; in_valid = v; out_ready = ordy; in_data = d;
      #1;
      rdy = in_ready;
      @(posedge clk);
      #1;
      ov = out_valid; od = out_data; src = out_src; err = sel_err;
   endtask

   initial begin
      logic [N*W-1:0] tw;
      logic [N*W-1:0] rd;
      logic [N-1:0]   rdy;
      logic           ov, err;
      logic [W-1:0]   od;
      logic [SW-1:0]  src;
      logic [N-1:0]   erdy;
      int             g;
      logic           r, md, ordy;
      logic [SW-1:0]  s;
      logic [N-1:0]   v;

      reset = 1'b1; mode = 1'b0; sel = '0; in_valid = '0; out_ready = 1'b0; in_data = '0;
      for (int i = 0; i < N; i++) tw[i*W +: W] = K + W'(i);

      add(1'b1, 1'b0, 3'd0, 6'h00, 1'b1, 6'h00, 1'b0, 32'h0,    3'd0, 1'b0);
      add(1'b0, 1'b0, 3'd2, 6'h04, 1'b1, 6'h04, 1'b1, K + 32'd2, 3'd2, 1'b0);
      add(1'b1, 1'b1, 3'd0, 6'h3F, 1'b1, 6'h08, 1'b0, 32'h0,    3'd0, 1'b0);
      for (int j = 0; j < 8; j++)
         add(1'b0, 1'b1, 3'd0, 6'h3F, 1'b1, model_rdy(j % N), 1'b1, K + W'(j % N),
             SW'(j % N), 1'b0);
      for (int j = 0; j < 3; j++)
         add(1'b0, 1'b1, 3'd0, 6'h3F, 1'b0, 6'h00, 1'b1, K + 32'd1, 3'd1, 1'b0);
      add(1'b0, 1'b1, 3'd0, 6'h3F, 1'b1, 6'h04, 1'b1, K + 32'd2, 3'd2, 1'b0);
      add(1'b0, 1'b1, 3'd0, 6'h00, 1'b1, 6'h00, 1'b0, K + 32'd2, 3'd2, 1'b0);
      add(1'b0, 1'b0, 3'd7, 6'h01, 1'b1, 6'h00, 1'b0, K + 32'd2, 3'd2, 1'b1);
      add(1'b0, 1'b0, 3'd0, 6'h01, 1'b1, 6'h01, 1'b1, K + 32'd0, 3'd0, 1'b0);
      add(1'b0, 1'b0, 3'd7, 6'h01, 1'b0, 6'h00, 1'b1, K + 32'd0, 3'd0, 1'b0);
      add(1'b0, 1'b0, 3'd7, 6'h01, 1'b1, 6'h00, 1'b0, K + 32'd0, 3'd0, 1'b1);
      add(1'b0, 1'b0, 3'd3, 6'h08, 1'b1, 6'h08, 1'b1, K + 32'd3, 3'd3, 1'b0);
      add(1'b0, 1'b1, 3'd0, 6'h22, 1'b1, 6'h20, 1'b1, K + 32'd5, 3'd5, 1'b0);
      add(1'b0, 1'b1, 3'd0, 6'h22, 1'b1, 6'h02, 1'b1, K + 32'd1, 3'd1, 1'b0);
      add(1'b0, 1'b1, 3'd0, 6'h22, 1'b1, 6'h20, 1'b1, K + 32'd5, 3'd5, 1'b0);
      add(1'b0, 1'b1, 3'd0, 6'h3F, 1'b0, 6'h00, 1'b1, K + 32'd5, 3'd5, 1'b0);
      add(1'b1, 1'b1, 3'd0, 6'h3F, 1'b0, 6'h00, 1'b0, 32'h0,    3'd0, 1'b0);
      add(1'b0, 1'b1, 3'd0, 6'h3F, 1'b1, 6'h01, 1'b1, K + 32'd0, 3'd0, 1'b0);

      foreach (tbl[i]) begin
         apply(tbl[i].rst, tbl[i].md, tbl[i].sl, tbl[i].iv, tbl[i].ordy, tw,
               rdy, ov, od, src, err);
         model_step(tbl[i].rst, tbl[i].md, tbl[i].sl, tbl[i].iv, tbl[i].ordy, tw);
         if (i != 0) chk($sformatf("v%0d.in_ready", i), 32'(rdy), 32'(tbl[i].erdy));
         chk($sformatf("v%0d.out_valid", i), 32'(ov),  32'(tbl[i].eov));
         chk($sformatf("v%0d.out_data", i),  od,       tbl[i].eod);
         chk($sformatf("v%0d.out_src", i),   32'(src), 32'(tbl[i].esrc));
         chk($sformatf("v%0d.sel_err", i),   32'(err), 32'(tbl[i].eerr));
      end

      for (int c = 0; c < 400; c++) begin
         r    = ($urandom_range(0, 39) == 0);
         md   = 1'($urandom_range(0, 1));
         s    = SW'($urandom_range(0, 7));
         v    = N'($urandom);
         ordy = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < N; i++) rd[i*W +: W] = $urandom;
         g    = model_grant(md, s, v, ordy);
         erdy = model_rdy(g);
         apply(r, md, s, v, ordy, rd, rdy, ov, od, src, err);
         model_step(r, md, s, v, ordy, rd);
         chk($sformatf("r%0d.in_ready", c),  32'(rdy), 32'(erdy));
         chk($sformatf("r%0d.out_valid", c), 32'(ov),  32'(m_ov));
         chk($sformatf("r%0d.out_data", c),  od,       m_od);
         chk($sformatf("r%0d.out_src", c),   32'(src), 32'(m_src));
         chk($sformatf("r%0d.sel_err", c),   32'(err), 32'(m_err));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
